// File: rtl/fc_argmax_pkg.sv
// Shared definitions for the FC2 argmax classification stage.
package fc_argmax_pkg;

  localparam int unsigned NUM_CLASSES = 10;
  localparam int unsigned SCORE_W     = 16;
  localparam int unsigned EXP_W       = 5;
  localparam int unsigned MANT_W      = 10;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned SCORES_W    = NUM_CLASSES * SCORE_W;

  typedef logic [SCORE_W-1:0] score_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/float16_greater.sv
// Float16 strict "a > b" comparator.
// Ports: a, b - Float16 operands; a_gt_b - high when a orders strictly above b.
// +0 and -0 compare equal; exponent 31 is treated as a plain magnitude (no NaN handling).
module float16_greater
  import fc_argmax_pkg::*;
(
  input  logic [SCORE_W-1:0] a,
  input  logic [SCORE_W-1:0] b,
  output logic               a_gt_b
);

  logic                      a_sign;
  logic                      b_sign;
  logic [EXP_W+MANT_W-1:0]   a_mag;
  logic [EXP_W+MANT_W-1:0]   b_mag;
  logic                      both_zero;

  assign a_sign    = a[SCORE_W-1];
  assign b_sign    = b[SCORE_W-1];
  assign a_mag     = a[EXP_W+MANT_W-1:0];
  assign b_mag     = b[EXP_W+MANT_W-1:0];
  assign both_zero = (a_mag == '0) && (b_mag == '0);

  // Sign-magnitude ordering: negatives invert the magnitude compare.
  always_comb begin
    a_gt_b = 1'b0;
    if (both_zero) begin
      a_gt_b = 1'b0;
    end else if (a_sign != b_sign) begin
      a_gt_b = ~a_sign;
    end else if (!a_sign) begin
      a_gt_b = (a_mag > b_mag);
    end else begin
      a_gt_b = (a_mag < b_mag);
    end
  end

endmodule

// File: rtl/fc_argmax.sv
// Sequential argmax over the ten FC2 Float16 class scores, one score per cycle.
// Ports: clk, iRst_n (async active-low), ena (sync clear), start (FC2 done level,
//        rising edge launches), scores (packed, score i at [16*i+15 -: 16]),
//        overflow_in; outputs digit, max_score, onehot, valid, busy, overflow.
module fc_argmax
  import fc_argmax_pkg::*;
(
  input  logic                   clk,
  input  logic                   iRst_n,
  input  logic                   ena,
  input  logic                   start,
  input  logic [SCORES_W-1:0]    scores,
  input  logic                   overflow_in,
  output logic [IDX_W-1:0]       digit,
  output logic [SCORE_W-1:0]     max_score,
  output logic [NUM_CLASSES-1:0] onehot,
  output logic                   valid,
  output logic                   busy,
  output logic                   overflow
);

  state_e           state_q, state_nxt;
  logic             start_d_q, start_d_nxt;
  score_t           best_q, best_nxt;
  logic [IDX_W-1:0] best_idx_q, best_idx_nxt;
  logic [IDX_W-1:0] cnt_q, cnt_nxt;
  score_t           score_buf [NUM_CLASSES];

  logic [IDX_W-1:0]       digit_nxt;
  score_t                 max_score_nxt;
  logic [NUM_CLASSES-1:0] onehot_nxt;
  logic                   valid_nxt;
  logic                   busy_nxt;
  logic                   overflow_nxt;

  logic   launch_c;
  logic   load_c;
  score_t cand_c;
  logic   cand_gt_c;

  assign launch_c = start & ~start_d_q & (state_q != SCAN);
  assign cand_c   = score_buf[cnt_q];

  float16_greater u_cmp (
    .a      (cand_c),
    .b      (best_q),
    .a_gt_b (cand_gt_c)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q    <= IDLE;
      start_d_q  <= 1'b0;
      best_q     <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
      digit      <= '0;
      max_score  <= '0;
      onehot     <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      start_d_q  <= start_d_nxt;
      best_q     <= best_nxt;
      best_idx_q <= best_idx_nxt;
      cnt_q      <= cnt_nxt;
      digit      <= digit_nxt;
      max_score  <= max_score_nxt;
      onehot     <= onehot_nxt;
      valid      <= valid_nxt;
      busy       <= busy_nxt;
      overflow   <= overflow_nxt;
    end
  end

  // Score snapshot taken at launch so later input changes are ignored.
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < int'(NUM_CLASSES); i++) score_buf[i] <= '0;
    end else if (load_c) begin
      for (int i = 0; i < int'(NUM_CLASSES); i++) score_buf[i] <= scores[i*SCORE_W +: SCORE_W];
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_nxt     = state_q;
    start_d_nxt   = start;
    best_nxt      = best_q;
    best_idx_nxt  = best_idx_q;
    cnt_nxt       = cnt_q;
    digit_nxt     = digit;
    max_score_nxt = max_score;
    onehot_nxt    = onehot;
    valid_nxt     = valid;
    busy_nxt      = busy;
    overflow_nxt  = overflow;
    load_c        = 1'b0;

    if (!ena) begin
      state_nxt     = IDLE;
      best_nxt      = '0;
      best_idx_nxt  = '0;
      cnt_nxt       = '0;
      digit_nxt     = '0;
      max_score_nxt = '0;
      onehot_nxt    = '0;
      valid_nxt     = 1'b0;
      busy_nxt      = 1'b0;
      overflow_nxt  = 1'b0;
    end else if (launch_c) begin
      // Score 0 seeds the running maximum; the scan starts at index 1.
      load_c        = 1'b1;
      state_nxt     = SCAN;
      best_nxt      = scores[SCORE_W-1:0];
      best_idx_nxt  = '0;
      cnt_nxt       = IDX_W'(1);
      busy_nxt      = 1'b1;
      valid_nxt     = 1'b0;
      onehot_nxt    = '0;
      overflow_nxt  = overflow_in;
    end else begin
      case (state_q)
        SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (cand_gt_c) begin
            best_nxt     = cand_c;
            best_idx_nxt = cnt_q;
          end
          cnt_nxt = cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(NUM_CLASSES - 1)) state_nxt = DONE;
        end
        DONE: begin
          digit_nxt     = best_idx_q;
          max_score_nxt = best_q;
          onehot_nxt    = NUM_CLASSES'(1) << best_idx_q;
          valid_nxt     = 1'b1;
          busy_nxt      = 1'b0;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Scoreboard bench for fc_argmax: stimulus queues expected results, a monitor
// checks each rising edge of valid against the queue head.
module tb_fc_argmax;
  import fc_argmax_pkg::*;

  logic                   clk = 1'b0;
  logic                   iRst_n;
  logic                   ena;
  logic                   start;
  logic [SCORES_W-1:0]    scores;
  logic                   overflow_in;
  logic [IDX_W-1:0]       digit;
  logic [SCORE_W-1:0]     max_score;
  logic [NUM_CLASSES-1:0] onehot;
  logic                   valid;
  logic                   busy;
  logic                   overflow;

  typedef struct {
    logic [3:0]  digit;
    logic [15:0] max;
    logic        ovf;
    int unsigned edge_n;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned edge_cnt = 0;
  int          checks   = 0;
  int          errors   = 0;

  fc_argmax dut (
    .clk         (clk),
    .iRst_n      (iRst_n),
    .ena         (ena),
    .start       (start),
    .scores      (scores),
    .overflow_in (overflow_in),
    .digit       (digit),
    .max_score   (max_score),
    .onehot      (onehot),
    .valid       (valid),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_digit"},  32'(digit),     32'h0);
    check({tag, "_max"},    32'(max_score), 32'h0);
    check({tag, "_onehot"}, 32'(onehot),    32'h0);
    check({tag, "_valid"},  32'(valid),     32'h0);
    check({tag, "_busy"},   32'(busy),      32'h0);
    check({tag, "_ovf"},    32'(overflow),  32'h0);
  endtask

  // Drives a launch at the next falling edge; optionally queues the expected result.
  task automatic launch_scan(input logic [SCORES_W-1:0] s, input logic ovf, input logic push,
                             input logic [3:0] d, input logic [15:0] m, input logic hold);
    exp_t e;
    @(negedge clk);
    scores      = s;
    overflow_in = ovf;
    start       = 1'b1;
    if (push) begin
      e.digit  = d;
      e.max    = m;
      e.ovf    = ovf;
      e.edge_n = edge_cnt + 11;
      exp_q.push_back(e);
    end
    if (!hold) begin
      @(negedge clk);
      start       = 1'b0;
      scores      = {NUM_CLASSES{16'h7BFF}};
      overflow_in = ~ovf;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d results pending, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every rising edge of valid must match the oldest queued expectation.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid: got valid=1 digit=%0d, expected no result", digit);
        end else begin
          e = exp_q.pop_front();
          check("digit",   32'(digit),     32'(e.digit));
          check("max",     32'(max_score), 32'(e.max));
          check("onehot",  32'(onehot),    32'(10'd1 << e.digit));
          check("ovf",     32'(overflow),  32'(e.ovf));
          check("busy",    32'(busy),      32'h0);
          check("latency", 32'(edge_cnt),  32'(e.edge_n));
        end
      end
      prev_valid = valid;
    end
  end

  initial begin
    logic [SCORES_W-1:0] s;
    iRst_n      = 1'b0;
    ena         = 1'b1;
    start       = 1'b0;
    scores      = '0;
    overflow_in = 1'b0;
    #13;
    check_cleared("reset");
    @(negedge clk);
    iRst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single positive maximum at index 7.
    s = '0;
    s[7*16 +: 16] = 16'h4000;
    launch_scan(s, 1'b0, 1'b1, 4'd7, 16'h4000, 1'b0);
    drain("t1");

    // Tie at 1.0 between indices 2 and 5; a start pulse mid-scan must be ignored.
    s = {NUM_CLASSES{16'hBC00}};
    s[2*16 +: 16] = 16'h3C00;
    s[5*16 +: 16] = 16'h3C00;
    launch_scan(s, 1'b0, 1'b1, 4'd2, 16'h3C00, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("t2");

    // All negative: -0.5 at index 9 beats -1.0 elsewhere.
    s = {NUM_CLASSES{16'hBC00}};
    s[9*16 +: 16] = 16'hB800;
    launch_scan(s, 1'b0, 1'b1, 4'd9, 16'hB800, 1'b0);
    drain("t3");

    // -0 at index 0 equals +0 elsewhere: index 0 kept.
    s = '0;
    s[0 +: 16] = 16'h8000;
    launch_scan(s, 1'b0, 1'b1, 4'd0, 16'h8000, 1'b0);
    drain("t4");

    // Infinity with overflow, start held high: exactly one scan.
    s = {NUM_CLASSES{16'h3C00}};
    s[4*16 +: 16] = 16'h7C00;
    launch_scan(s, 1'b1, 1'b1, 4'd4, 16'h7C00, 1'b1);
    drain("t5");
    repeat (20) @(negedge clk);
    check("hold_valid", 32'(valid), 32'h1);
    check("hold_digit", 32'(digit), 32'h4);
    check("hold_busy",  32'(busy),  32'h0);
    start = 1'b0;

    // Reset in the middle of a scan.
    s = '0;
    s[3*16 +: 16] = 16'h5000;
    launch_scan(s, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("midscan_busy", 32'(busy), 32'h1);
    iRst_n = 1'b0;
    #1;
    check_cleared("midreset");
    repeat (2) @(negedge clk);
    iRst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_reset_valid", 32'(valid), 32'h0);
    s = '0;
    s[7*16 +: 16] = 16'h4000;
    launch_scan(s, 1'b0, 1'b1, 4'd7, 16'h4000, 1'b0);
    drain("t6");

    // ena low clears a valid result; held start must not relaunch afterwards.
    @(negedge clk);
    ena   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check_cleared("ena_low");
    ena = 1'b1;
    repeat (15) @(negedge clk);
    check("ena_nolaunch_busy",  32'(busy),  32'h0);
    check("ena_nolaunch_valid", 32'(valid), 32'h0);
    start = 1'b0;
    s = {NUM_CLASSES{16'hBC00}};
    s[9*16 +: 16] = 16'hB800;
    launch_scan(s, 1'b0, 1'b1, 4'd9, 16'hB800, 1'b0);
    drain("t7");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_argmax.md
Name: fc_argmax

Overview:
- Classification stage directly downstream of the second fully-connected layer.
- Takes the ten Float16 class scores that layer produces, plus its done and overflow flags.
- Scans the scores sequentially, one per cycle, and reports the index of the largest score as the recognised digit (0-9), along with that score and a one-hot LED vector for the board.

Parameters:
bit, 16, width of one Float16 score
NUM_CLASSES, 10, number of scores scanned (fixed to 10 for the digit task)

Ports:
clk  input  1  system clock, rising edge
iRst_n  input  1  asynchronous active-low reset
ena  input  1  stage enable; low forces IDLE synchronously
start  input  1  FC2 done level; rising edge launches a scan
scores  input  NUM_CLASSES*bit  score i in bits [bit*i+bit-1 -: bit]
overflow_in  input  1  overflow flag from FC2
digit  output  4  index of the maximum score
max_score  output  bit  value of the maximum score
onehot  output  NUM_CLASSES  bit digit set when valid, else 0
valid  output  1  result stable
busy  output  1  scan in progress
overflow  output  1  overflow_in captured at launch

Behaviour:
- Reset (iRst_n low, async):
  - state=IDLE, all outputs 0 (digit=0, max_score=0, onehot=0, valid=0, busy=0, overflow=0).
  - start edge detector register cleared to 0.
- ena low (sync, takes priority over start):
  - same clearing as reset.
  - start_d <= start, so a held-high done does not relaunch when ena returns.
- Launch:
  - start_d registered each cycle; launch = start & ~start_d in IDLE or DONE.
- States:
  - IDLE: on launch, latch scores into an internal buffer and capture overflow_in. Set best=score0, best_idx=0, cnt=1, busy=1, valid=0, onehot=0. Go to SCAN.
  - SCAN: each cycle compare buf[cnt] against best. If strictly greater, best<=buf[cnt] and best_idx<=cnt. cnt<=cnt+1. Processing cnt=9 goes to DONE.
  - DONE: on entry, drive digit=best_idx, max_score=best, onehot=1<<best_idx, valid=1, busy=0. Hold until launch (restarts a scan, clears valid) or ena low / reset.
- Latency: launch edge = edge 0; SCAN occupies edges 1-9; valid high after edge 10.
- start pulses during SCAN are ignored; scores changing after launch are ignored (buffered).
- Float16 ordering (comparator a>b):
  - +0 and -0 are equal.
  - Signs differ: the positive value wins unless both are zero.
  - Both positive: larger {exp,mant} wins.
  - Both negative: smaller {exp,mant} wins.
  - Exponent 31 is ordered as a plain magnitude (Inf largest). No NaN handling.
- Ties keep the lowest index (strict greater replaces).
- Reset mid-scan aborts immediately; no partial result is ever flagged valid.

Decomposition:
- Shared package:
  - NUM_CLASSES=10.
  - Float16 field widths (EXP_W=5, MANT_W=10).
  - State encoding IDLE/SCAN/DONE.
- One combinational sub-module, float16_greater:
  - inputs a, b; output a_gt_b; implements the ordering above.
  - Reusable by later pooling/ReLU stages.

Test Plan:
- scores all 0000 except index 7 = 4000 (2.0), raise start -> after edge 10: valid=1, digit=7, max_score=4000, onehot=0x080, busy low.
- index 2 = 3C00 and index 5 = 3C00, rest BC00 -> digit=2 (lowest-index tie).
- all negative: BC00 except index 9 = B800 (-0.5) -> digit=9, max_score=B800. Second case: index 0 = 8000 (-0), rest 0000 -> digit=0 (zeros equal).
- overflow_in=1 at launch with index 4 = 7C00 (Inf) -> digit=4, overflow=1. Hold start high for 30 cycles -> exactly one scan, valid stays 1.
- Reset low at edge 5 of a scan -> all outputs 0 immediately. Release and relaunch -> correct result 10 edges later.
- ena low while valid -> valid/onehot cleared next edge. ena high with start still high -> no launch until start falls and rises again.
